// File: rtl/mult_rom_pkg.sv
// mult_rom_pkg: shared definitions for the nibble ROM multiplier.
//   DIGIT_W          - digit width in bits (one ROM lookup per digit pair)
//   state_t          - controller states
//   prod_table_t     - flattened 16x16 table of 8-bit digit products, index {x,y}
//   build_prod_table - fills the table with x*y at elaboration
package mult_rom_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [255:0][7:0] prod_table_t;

  function automatic prod_table_t build_prod_table();
    prod_table_t t;
    logic [7:0]  idx;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        idx    = 8'(x * 16 + y);
        t[idx] = 8'(x * y);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/digit_prod_rom.sv
// digit_prod_rom: combinational 4x4 -> 8-bit product lookup.
//   x, y : 4-bit digits
//   p    : x*y
module digit_prod_rom
  import mult_rom_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  localparam prod_table_t TABLE = build_prod_table();

  assign p = TABLE[{x, y}];

endmodule

// File: rtl/nibble_rom_mult.sv
// nibble_rom_mult: sequential WIDTH x WIDTH multiplier accumulating one
// 4-bit digit-pair product per cycle from a 16x16 product ROM.
//   clk, rst             - clock, async active-low reset
//   in_valid/in_ready    - operand handshake (a, b, signed_mode)
//   out_valid/out_ready  - result handshake
//   result               - 2*WIDTH product, held while out_valid
//   busy                 - high whenever not IDLE
// Signed operands are multiplied as magnitudes; the sign is applied once
// in FIX so the digit loop stays purely unsigned.
module nibble_rom_mult
  import mult_rom_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = 2 * WIDTH;

  state_t            state, nstate;
  logic [WIDTH-1:0]  a_mag, b_mag, a_abs, b_abs;
  logic              neg;
  logic [RW-1:0]     acc, res_q, term;
  logic [IW-1:0]     i, j;
  logic [3:0]        a_dig, b_dig;
  logic [7:0]        prod;
  logic              last_pair, j_wrap;

  // -0x80 at WIDTH=8 yields 0x80, which is the correct magnitude unsigned.
  assign a_abs = (signed_mode & a[WIDTH-1]) ? -a : a;
  assign b_abs = (signed_mode & b[WIDTH-1]) ? -b : b;

  assign a_dig = 4'(a_mag >> (DIGIT_W * int'(i)));
  assign b_dig = 4'(b_mag >> (DIGIT_W * int'(j)));

  digit_prod_rom u_rom (.x(a_dig), .y(b_dig), .p(prod));

  assign term      = RW'(prod) << (DIGIT_W * (int'(i) + int'(j)));
  assign j_wrap    = (j == IW'(N - 1));
  assign last_pair = (i == IW'(N - 1)) && j_wrap;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = res_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (in_valid)  nstate = BUSY;
      BUSY:    if (last_pair) nstate = FIX;
      FIX:                    nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default:                nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_mag <= '0;
      b_mag <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      res_q <= '0;
      i     <= '0;
      j     <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_mag <= a_abs;
          b_mag <= b_abs;
          neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc   <= '0;
          i     <= '0;
          j     <= '0;
        end
        BUSY: begin
          acc <= acc + term;
          if (j_wrap) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        FIX:     res_q <= neg ? -acc : acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_rom_mult.sv
module tb_nibble_rom_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] abus = '0, bbus = '0;
  logic        smode = 1'b0;
  logic [3:0]  iv = '0, ordy = '0;
  wire  [3:0]  ir, ov, bz;
  wire  [7:0]  r4;
  wire  [15:0] r8;
  wire  [23:0] r12;
  wire  [31:0] r16;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  nibble_rom_mult #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(abus[3:0]), .b(bbus[3:0]),
    .signed_mode(smode), .out_valid(ov[0]), .out_ready(ordy[0]), .result(r4), .busy(bz[0]));
  nibble_rom_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(abus[7:0]), .b(bbus[7:0]),
    .signed_mode(smode), .out_valid(ov[1]), .out_ready(ordy[1]), .result(r8), .busy(bz[1]));
  nibble_rom_mult #(.WIDTH(12)) u12 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(abus[11:0]), .b(bbus[11:0]),
    .signed_mode(smode), .out_valid(ov[2]), .out_ready(ordy[2]), .result(r12), .busy(bz[2]));
  nibble_rom_mult #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(abus[15:0]), .b(bbus[15:0]),
    .signed_mode(smode), .out_valid(ov[3]), .out_ready(ordy[3]), .result(r16), .busy(bz[3]));

  function automatic logic [31:0] getres(input int k);
    case (k)
      0:       return {24'b0, r4};
      1:       return {16'b0, r8};
      2:       return {8'b0, r12};
      default: return r16;
    endcase
  endfunction

  // Reference: interpret operands per mode, multiply as integers, wrap to 2w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] av, input logic [15:0] bv,
                                          input logic sm);
    longint sa, sb, p, m;
    m  = (longint'(1) << w) - 1;
    sa = longint'(av) & m;
    sb = longint'(bv) & m;
    if (sm && av[w-1]) sa = sa - (longint'(1) << w);
    if (sm && bv[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Offer one transaction on instance k, return result and edges from accept to out_valid.
  task automatic run_txn(input int k, input logic [15:0] av, input logic [15:0] bv, input logic sm,
                         output logic [31:0] r, output int lat);
    @(negedge clk);
    abus = av; bbus = bv; smode = sm; iv[k] = 1'b1; ordy[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    lat = 0;
    while (!ov[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = getres(k);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || bz[k] !== 1'b0 || getres(k) !== 32'h0) begin
        nmis++;
        $display("FAIL reset_state inst%0d: ir=%b ov=%b busy=%b res=%h, want 1 0 0 0",
                 k, ir[k], ov[k], bz[k], getres(k));
      end
    end
  endtask

  task automatic test_unsigned_max();
    logic [31:0] r; int lat;
    run_txn(1, 16'hFF, 16'hFF, 1'b0, r, lat);
    nvec++;
    if (r !== 32'hFE01) begin nmis++; $display("FAIL u8_ffxff: got %h want fe01", r); end
    nvec++;
    if (lat !== 5) begin nmis++; $display("FAIL u8_latency: got %0d want 5", lat); end
    @(negedge clk);
    nvec++;
    if (ov[1] !== 1'b0 || ir[1] !== 1'b1) begin
      nmis++; $display("FAIL u8_single_cycle_valid: ov=%b ir=%b want 0 1", ov[1], ir[1]);
    end
  endtask

  task automatic test_signed();
    logic [15:0] av[3] = '{16'h80, 16'h80, 16'hFD};
    logic [15:0] bv[3] = '{16'h7F, 16'h80, 16'h05};
    logic [31:0] ex[3] = '{32'hC080, 32'h4000, 32'hFFF1};
    logic [31:0] r; int lat;
    for (int t = 0; t < 3; t++) begin
      run_txn(1, av[t], bv[t], 1'b1, r, lat);
      nvec++;
      if (r !== ex[t]) begin
        nmis++; $display("FAIL s8_%h_x_%h: got %h want %h", av[t][7:0], bv[t][7:0], r, ex[t]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    abus = 16'd3; bbus = 16'd7; smode = 1'b0; iv[1] = 1'b1; ordy[1] = 1'b0;
    @(negedge clk);
    abus = 16'd9; bbus = 16'd9;   // new operands offered continuously
    n = 0;
    while (!ov[1] && n < 100) begin @(negedge clk); n++; end
    for (int c = 0; c < 10; c++) begin
      nvec++;
      if (ov[1] !== 1'b1 || ir[1] !== 1'b0 || r8 !== 16'd21) begin
        nmis++; $display("FAIL bp_hold c%0d: ov=%b ir=%b res=%h want 1 0 0015", c, ov[1], ir[1], r8);
      end
      @(negedge clk);
    end
    ordy[1] = 1'b1;
    @(negedge clk);
    nvec++;
    if (ir[1] !== 1'b1 || bz[1] !== 1'b0) begin
      nmis++; $display("FAIL bp_no_same_cycle_accept: ir=%b busy=%b want 1 0", ir[1], bz[1]);
    end
    @(negedge clk);
    iv[1] = 1'b0;
    nvec++;
    if (bz[1] !== 1'b1) begin nmis++; $display("FAIL bp_accept_after: busy=%b want 1", bz[1]); end
    n = 0;
    while (!ov[1] && n < 100) begin @(negedge clk); n++; end
    nvec++;
    if (r8 !== 16'd81) begin nmis++; $display("FAIL bp_second_result: got %h want 0051", r8); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat;
    @(negedge clk);
    abus = 16'hAB; bbus = 16'hCD; smode = 1'b0; iv[1] = 1'b1; ordy[1] = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    nvec++;
    if (ov[1] !== 1'b0 || bz[1] !== 1'b0 || ir[1] !== 1'b1 || r8 !== 16'h0) begin
      nmis++; $display("FAIL mid_reset: ov=%b busy=%b ir=%b res=%h want 0 0 1 0000",
                       ov[1], bz[1], ir[1], r8);
    end
    @(negedge clk);
    rst = 1'b1;
    run_txn(1, 16'h03, 16'h05, 1'b0, r, lat);
    nvec++;
    if (r !== 32'h000F || lat !== 5) begin
      nmis++; $display("FAIL post_reset_3x5: got %h lat %0d want 000f lat 5", r, lat);
    end
  endtask

  task automatic test_w16();
    logic [31:0] r; int lat;
    run_txn(3, 16'hFFFF, 16'hFFFF, 1'b0, r, lat);
    nvec++;
    if (r !== 32'hFFFE0001 || lat !== 17) begin
      nmis++; $display("FAIL u16_max: got %h lat %0d want fffe0001 lat 17", r, lat);
    end
    run_txn(3, 16'h1234, 16'h0000, 1'b0, r, lat);
    nvec++;
    if (r !== 32'h0) begin nmis++; $display("FAIL u16_zero: got %h want 0", r); end
    run_txn(3, 16'hFFFF, 16'hFFFF, 1'b1, r, lat);
    nvec++;
    if (r !== 32'h1) begin nmis++; $display("FAIL s16_m1xm1: got %h want 00000001", r); end
  endtask

  task automatic test_random();
    logic [31:0] r, ex; logic [15:0] av, bv, m; logic sm; int lat, w;
    for (int k = 0; k < 4; k++) begin
      w = 4 * (k + 1);
      m = 16'((32'h1 << w) - 1);
      for (int t = 0; t < 1000; t++) begin
        av = 16'($urandom) & m;
        bv = 16'($urandom) & m;
        sm = 1'($urandom);
        ex = ref_mul(w, av, bv, sm);
        run_txn(k, av, bv, sm, r, lat);
        nvec++;
        if (r !== ex || lat !== (w / 4) * (w / 4) + 1) begin
          nmis++;
          $display("FAIL rand_w%0d %h x %h s%b: got %h lat %0d want %h lat %0d",
                   w, av, bv, sm, r, lat, ex, (w / 4) * (w / 4) + 1);
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_unsigned_max();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_w16();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
